mat_cache_reader: RTL and testbench

- Read-side drain engine for a MatCache instance; the counterpart of the row/column writers that fill the cache.
- On `start`, walks one WIDTH x WIDTH matrix slot. Each step is either a row (MAT_DATA_READ_ROW) or a diagonal (MAT_DATA_READ_DIAG) with param 0..WIDTH-1.
- Captures each WIDTH-wide vector and serializes it, one element per beat, onto a valid/ready stream feeding the host-side output path.

---
 rtl/mat_cache_reader.sv | 177 +++++++++++++++++
 tb/tb_mat_cache_reader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_cache_reader.sv
// mat_cache_reader: drains one WIDTH x WIDTH MatCache slot (rows or diagonals) as a stream of elements.
// Latency: cache read one cycle after start, first element the cycle after. Optional macro MAT_READER_PREFETCH_EN removes the per-vector fetch bubble.
// Backpressure: out_valid/out_data/out_vec/out_idx hold while out_ready is low. The next vector is fetched only after the last handshake.

typedef enum logic [1:0] {
    MAT_DATA_READ_ROW  = 2'd0,
    MAT_DATA_READ_DIAG = 2'd1
} MatDataReadOp_t;

module mat_cache_reader #(
    parameter int WIDTH      = 4,
    parameter int CACHE_SIZE = 4,
    parameter int DATA_BITS  = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [$clog2(CACHE_SIZE)-1:0]   start_addr,
    input  logic                            start_diag,
    output logic                            busy,
    output MatDataReadOp_t                  read_op,
    output logic [$clog2(CACHE_SIZE)-1:0]   read_addr1,
    output logic [$clog2(CACHE_SIZE)-1:0]   read_addr2,
    output logic [$clog2(WIDTH)-1:0]        read_param,
    input  logic [WIDTH-1:0][DATA_BITS-1:0] data_out,
    output logic [DATA_BITS-1:0]            out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(WIDTH)-1:0]        out_vec,
    output logic [$clog2(WIDTH)-1:0]        out_idx,
    output logic                            out_last,
    output logic                            done
);
    localparam int AW = $clog2(CACHE_SIZE);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic [IW-1:0]                   vec_q, vec_d;
    logic [IW-1:0]                   elem_q, elem_d;
    MatDataReadOp_t                  op_q, op_d;
    logic [AW-1:0]                   addr_q, addr_d;
    logic [IW-1:0]                   param_q, param_d;
    logic [WIDTH-1:0][DATA_BITS-1:0] buf0_q, buf0_d;
    logic                            hs;
`ifdef MAT_READER_PREFETCH_EN
    localparam logic [IW-1:0] PENULT_IDX = IW'(WIDTH - 2);
    logic [WIDTH-1:0][DATA_BITS-1:0] buf1_q, buf1_d;
    logic                            sel_q, sel_d;       // buffer currently being streamed
    logic                            pf_done_q, pf_done_d; // next vector already captured
`endif

    assign busy       = (state_q == S_FETCH) || (state_q == S_STREAM);
    assign done       = (state_q == S_DONE);
    assign out_valid  = (state_q == S_STREAM);
    assign out_last   = out_valid && (vec_q == LAST_IDX) && (elem_q == LAST_IDX);
    assign out_vec    = vec_q;
    assign out_idx    = elem_q;
    assign hs         = out_valid && out_ready;
    assign read_op    = op_q;
    assign read_addr1 = addr_q;
    assign read_addr2 = addr_q;
    assign read_param = param_q;
`ifdef MAT_READER_PREFETCH_EN
    assign out_data   = sel_q ? buf1_q[elem_q] : buf0_q[elem_q];
`else
    assign out_data   = buf0_q[elem_q];
`endif

    // Next state: FSM transitions, element/vector counters, cache request and vector capture
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        elem_d  = elem_q;
        op_d    = op_q;
        addr_d  = addr_q;
        param_d = param_q;
        buf0_d  = buf0_q;
`ifdef MAT_READER_PREFETCH_EN
        buf1_d    = buf1_q;
        sel_d     = sel_q;
        pf_done_d = pf_done_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    vec_d   = '0;
                    elem_d  = '0;
                    addr_d  = start_addr;
                    op_d    = start_diag ? MAT_DATA_READ_DIAG : MAT_DATA_READ_ROW;
                    param_d = '0;
                end
            end
            S_FETCH: begin
                // Cache read is combinational: capture in the cycle the address is presented
`ifdef MAT_READER_PREFETCH_EN
                if (sel_q) buf1_d = data_out;
                else       buf0_d = data_out;
                pf_done_d = 1'b0;
`else
                buf0_d = data_out;
`endif
                elem_d  = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
`ifdef MAT_READER_PREFETCH_EN
                // Point the cache at vec+1 as the last element comes up, capture it once into the idle buffer
                if (hs && (elem_q == PENULT_IDX) && (vec_q != LAST_IDX)) begin
                    param_d = vec_q + IW'(1);
                end
                if ((elem_q == LAST_IDX) && (vec_q != LAST_IDX) && !pf_done_q) begin
                    if (sel_q) buf0_d = data_out;
                    else       buf1_d = data_out;
                    pf_done_d = 1'b1;
                end
`endif
                if (hs) begin
                    if (elem_q == LAST_IDX) begin
                        elem_d = '0;
                        if (vec_q == LAST_IDX) begin
                            vec_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            vec_d = vec_q + IW'(1);
`ifdef MAT_READER_PREFETCH_EN
                            sel_d     = ~sel_q;
                            pf_done_d = 1'b0;
`else
                            param_d = vec_q + IW'(1);
                            state_d = S_FETCH;
`endif
                        end
                    end else begin
                        elem_d = elem_q + IW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any drain in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            elem_q  <= '0;
            op_q    <= MAT_DATA_READ_ROW;
            addr_q  <= '0;
            param_q <= '0;
            buf0_q  <= '0;
`ifdef MAT_READER_PREFETCH_EN
            buf1_q    <= '0;
            sel_q     <= 1'b0;
            pf_done_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            elem_q  <= elem_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            param_q <= param_d;
            buf0_q  <= buf0_d;
`ifdef MAT_READER_PREFETCH_EN
            buf1_q    <= buf1_d;
            sel_q     <= sel_d;
            pf_done_q <= pf_done_d;
`endif
        end
    end
endmodule

// File: tb/tb_mat_cache_reader.sv
// tb_mat_cache_reader: scoreboard bench for mat_cache_reader with a combinational cache model.
// Expected beats are queued at each start and compared against handshaken beats.
// Timing expectations follow MAT_READER_PREFETCH_EN when it is defined.

module tb_mat_cache_reader;
    localparam int WIDTH      = 4;
    localparam int CACHE_SIZE = 4;
    localparam int DATA_BITS  = 32;
    localparam int AW         = 2;
    localparam int IW         = 2;
    localparam logic [1:0] OP_ROW  = 2'd0;
    localparam logic [1:0] OP_DIAG = 2'd1;
`ifdef MAT_READER_PREFETCH_EN
    localparam int SPAN = 17;   // FETCH cycle through last handshake, no bubbles
`else
    localparam int SPAN = 20;   // (WIDTH+1)*WIDTH
`endif
    // slot 0 matrix rows, and its diagonals as listed for the cache
    localparam int S0 [16] = '{4, 6, 1, 6,  1, 2, 3, 4,  3, 3, 3, 3,  9, 7, 5, 3};
    localparam int D0 [16] = '{4, 4, 3, 7,  6, 1, 3, 5,  1, 2, 3, 3,  6, 3, 3, 9};
    localparam bit RPAT [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    logic                            clock = 1'b0;
    logic                            reset = 1'b0;
    logic                            start = 1'b0;
    logic [AW-1:0]                   start_addr = '0;
    logic                            start_diag = 1'b0;
    logic                            busy;
    logic [1:0]                      read_op;
    logic [AW-1:0]                   read_addr1, read_addr2;
    logic [IW-1:0]                   read_param;
    logic [WIDTH-1:0][DATA_BITS-1:0] data_out;
    logic [DATA_BITS-1:0]            out_data;
    logic                            out_valid;
    logic                            out_ready = 1'b0;
    logic [IW-1:0]                   out_vec, out_idx;
    logic                            out_last, done;

    typedef struct {
        logic [31:0]   data;
        logic [IW-1:0] vec;
        logic [IW-1:0] idx;
        logic          last;
        logic [IW-1:0] rp;
        logic [1:0]    op;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int r_n_hs, r_t_first, r_t_last, r_t_done, r_n_done, r_hold_err, r_misc_err, r_extra;
    bit r_tmo;

    mat_cache_reader #(.WIDTH(WIDTH), .CACHE_SIZE(CACHE_SIZE), .DATA_BITS(DATA_BITS)) dut (
        .clock(clock), .reset(reset), .start(start), .start_addr(start_addr), .start_diag(start_diag),
        .busy(busy), .read_op(read_op), .read_addr1(read_addr1), .read_addr2(read_addr2),
        .read_param(read_param), .data_out(data_out), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_vec(out_vec), .out_idx(out_idx), .out_last(out_last), .done(done)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] fp(input int n);
        case (n)
            1:       return 32'h3F80_0000;
            2:       return 32'h4000_0000;
            3:       return 32'h4040_0000;
            4:       return 32'h4080_0000;
            5:       return 32'h40A0_0000;
            6:       return 32'h40C0_0000;
            7:       return 32'h40E0_0000;
            9:       return 32'h4110_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] mat_val(input int s, input int r, input int c);
        logic [31:0] v;
        if (s == 0) return fp(S0[r*WIDTH + c]);
        v = 32'hA000_005A;
        v[23:16] = 8'(s);
        v[15:8]  = 8'(r);
        v[11:8]  = 4'(r);
        v[7:4]   = 4'(c);
        return v;
    endfunction

    // Cache model: diagonal d lane j is M[j][(d - j) mod WIDTH]
    always_comb begin
        for (int j = 0; j < WIDTH; j++) begin
            if (read_op == OP_DIAG)
                data_out[j] = mat_val(int'(read_addr1), j, (int'(read_param) - j + WIDTH) % WIDTH);
            else
                data_out[j] = mat_val(int'(read_addr1), int'(read_param), j);
        end
    end

    task automatic push_expected(input int slot, input bit diag);
        beat_t e;
        for (int v = 0; v < WIDTH; v++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (slot == 0) e.data = fp(diag ? D0[v*WIDTH + j] : S0[v*WIDTH + j]);
                else e.data = diag ? mat_val(slot, j, (v - j + WIDTH) % WIDTH) : mat_val(slot, v, j);
                e.vec  = IW'(v);
                e.idx  = IW'(j);
                e.last = (v == WIDTH-1) && (j == WIDTH-1);
                e.rp   = IW'(v);
                e.op   = diag ? OP_DIAG : OP_ROW;
                e.a1   = AW'(slot);
                e.a2   = AW'(slot);
                exp_q.push_back(e);
            end
        end
    endtask

    // Starts a drain and records every handshaken beat; stops after done (plus idle cycles) or at abort_hs beats
    task automatic run_drain(input int slot, input bit diag, input int rmode, input int abort_hs, input bit poke);
        bit pv = 1'b0;
        bit seen_done = 1'b0;
        int post = 0;
        logic [31:0] pd = '0;
        logic [IW-1:0] pvec = '0, pidx = '0;
        beat_t b;
        r_n_hs = 0; r_t_first = -1; r_t_last = -1; r_t_done = -1; r_n_done = 0;
        r_hold_err = 0; r_misc_err = 0; r_extra = 0; r_tmo = 1'b0;
        push_expected(slot, diag);
        @(negedge clock);
        start_addr = AW'(slot); start_diag = diag; start = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clock);
            if (poke) begin
                start = (t == 6) || (done === 1'b1);
                if (start) start_addr = AW'(slot + 1 + int'(done));
            end else if (t == 0) begin
                start = 1'b0;
            end
            out_ready = (rmode == 0) ? 1'b1 : RPAT[t % 4];
            if (pv && !(out_valid && out_data === pd && out_vec === pvec && out_idx === pidx)) r_hold_err++;
            pv = out_valid && !out_ready; pd = out_data; pvec = out_vec; pidx = out_idx;
            if ((t == 0 && !busy) || (out_valid && !busy) || (out_last && !out_valid)) r_misc_err++;
            if (out_valid && out_ready) begin
                b.data = out_data; b.vec = out_vec; b.idx = out_idx; b.last = out_last;
                b.rp = read_param; b.op = read_op; b.a1 = read_addr1; b.a2 = read_addr2;
                obs_q.push_back(b);
                r_n_hs++;
                if (r_t_first < 0) r_t_first = t;
                r_t_last = t;
            end
            if (seen_done && !done && (busy || out_valid)) r_extra++;
            if (done) begin
                r_n_done++;
                if (busy) r_misc_err++;
                if (!seen_done) r_t_done = t;
                seen_done = 1'b1;
            end
            if (seen_done) post++;
            if (post > 6) break;
            if (abort_hs > 0 && r_n_hs == abort_hs) break;
        end
        start = 1'b0;
        if (!seen_done && abort_hs == 0) r_tmo = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; start_addr = 2'd3;
        repeat (2) @(negedge clock);
        n_checks++; if ({busy, out_valid, out_last, done} !== 4'b0000) begin n_errors++; $display("FAIL reset_ctrl: got %b need 0000", {busy, out_valid, out_last, done}); end
        n_checks++; if (out_data !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h need 0", out_data); end
        n_checks++; if ({out_vec, out_idx} !== 4'h0) begin n_errors++; $display("FAIL reset_idx: got %h need 0", {out_vec, out_idx}); end
        n_checks++; if ({read_op, read_addr1, read_addr2, read_param} !== 8'h00) begin n_errors++; $display("FAIL reset_cache_if: got %h need 00", {read_op, read_addr1, read_addr2, read_param}); end
        reset = 1'b0; start = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if ({busy, out_valid} !== 2'b00) begin n_errors++; $display("FAIL idle_after_reset: got %b need 00", {busy, out_valid}); end
    endtask

    task automatic test_row_drain();
        beat_t ob, ex;
        run_drain(0, 1'b0, 0, 0, 1'b0);
        while (obs_q.size() > 0) begin
            ob = obs_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin n_errors++; $display("FAIL row_beat: extra beat got %h need none", ob.data); continue; end
            ex = exp_q.pop_front();
            if ({ob.data, ob.vec, ob.idx, ob.last, ob.op, ob.a1, ob.a2} !== {ex.data, ex.vec, ex.idx, ex.last, ex.op, ex.a1, ex.a2}) begin
                n_errors++; $display("FAIL row_beat v%0d e%0d: got %h last=%b need %h last=%b", ex.vec, ex.idx, ob.data, ob.last, ex.data, ex.last);
            end
        end
        n_checks++; if (exp_q.size() != 0 || r_n_hs != 16) begin n_errors++; $display("FAIL row_count: got %0d beats need 16", r_n_hs); end
        exp_q.delete();
        n_checks++; if (r_t_first != 1) begin n_errors++; $display("FAIL row_first_valid: got cycle %0d need 1", r_t_first); end
        n_checks++; if (r_t_last + 1 != SPAN) begin n_errors++; $display("FAIL row_span: got %0d need %0d", r_t_last + 1, SPAN); end
        n_checks++; if (r_n_done != 1 || r_t_done != r_t_last + 1 || r_tmo) begin n_errors++; $display("FAIL row_done: got n=%0d at %0d need n=1 at %0d", r_n_done, r_t_done, r_t_last + 1); end
        n_checks++; if (r_misc_err != 0 || r_extra != 0) begin n_errors++; $display("FAIL row_busy: got %0d/%0d errors need 0", r_misc_err, r_extra); end
    endtask

    task automatic test_diag_drain();
        beat_t ob, ex;
        run_drain(0, 1'b1, 0, 0, 1'b0);
        while (obs_q.size() > 0) begin
            ob = obs_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin n_errors++; $display("FAIL diag_beat: extra beat got %h need none", ob.data); continue; end
            ex = exp_q.pop_front();
            if ({ob.data, ob.vec, ob.idx, ob.last, ob.op, ob.a1, ob.a2} !== {ex.data, ex.vec, ex.idx, ex.last, ex.op, ex.a1, ex.a2}) begin
                n_errors++; $display("FAIL diag_beat v%0d e%0d: got %h op=%0d need %h op=%0d", ex.vec, ex.idx, ob.data, ob.op, ex.data, ex.op);
            end
            if (ob.idx == 0) begin
                n_checks++;
                if (ob.rp !== ex.rp) begin n_errors++; $display("FAIL diag_param v%0d: got %0d need %0d", ex.vec, ob.rp, ex.rp); end
            end
        end
        n_checks++; if (exp_q.size() != 0 || r_n_hs != 16 || r_n_done != 1) begin n_errors++; $display("FAIL diag_count: got %0d beats %0d done need 16 1", r_n_hs, r_n_done); end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        beat_t ob, ex;
        run_drain(1, 1'b0, 1, 0, 1'b0);
        while (obs_q.size() > 0) begin
            ob = obs_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin n_errors++; $display("FAIL bp_beat: extra beat got %h need none", ob.data); continue; end
            ex = exp_q.pop_front();
            if ({ob.data, ob.vec, ob.idx, ob.last, ob.op, ob.a1, ob.a2} !== {ex.data, ex.vec, ex.idx, ex.last, ex.op, ex.a1, ex.a2}) begin
                n_errors++; $display("FAIL bp_beat v%0d e%0d: got %h need %h", ex.vec, ex.idx, ob.data, ex.data);
            end
        end
        n_checks++; if (exp_q.size() != 0 || r_n_hs != 16) begin n_errors++; $display("FAIL bp_count: got %0d need 16", r_n_hs); end
        exp_q.delete();
        n_checks++; if (r_hold_err != 0) begin n_errors++; $display("FAIL bp_hold: got %0d changes while stalled need 0", r_hold_err); end
        n_checks++; if (r_n_done != 1 || r_tmo) begin n_errors++; $display("FAIL bp_done: got %0d need 1", r_n_done); end
    endtask

    task automatic test_start_handling();
        beat_t ob, ex;
        run_drain(2, 1'b0, 0, 0, 1'b1);
        while (obs_q.size() > 0) begin
            ob = obs_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin n_errors++; $display("FAIL start_beat: extra beat got %h need none", ob.data); continue; end
            ex = exp_q.pop_front();
            if ({ob.data, ob.vec, ob.idx, ob.last, ob.op, ob.a1, ob.a2} !== {ex.data, ex.vec, ex.idx, ex.last, ex.op, ex.a1, ex.a2}) begin
                n_errors++; $display("FAIL start_beat v%0d e%0d: got %h addr=%0d need %h addr=%0d", ex.vec, ex.idx, ob.data, ob.a1, ex.data, ex.a1);
            end
        end
        n_checks++; if (exp_q.size() != 0 || r_n_hs != 16) begin n_errors++; $display("FAIL start_count: got %0d need 16", r_n_hs); end
        exp_q.delete();
        n_checks++; if (r_n_done != 1 || r_extra != 0) begin n_errors++; $display("FAIL start_ignored: got done=%0d extra=%0d need 1 0", r_n_done, r_extra); end
    endtask

    task automatic test_reset_mid_drain();
        beat_t ob, ex;
        int nd = 0;
        run_drain(3, 1'b0, 0, 9, 1'b0);
        reset = 1'b1;
        #1;
        n_checks++; if ({busy, out_valid, done} !== 3'b000) begin n_errors++; $display("FAIL rst_mid_ctrl: got %b need 000", {busy, out_valid, done}); end
        n_checks++; if ({read_addr1, read_param, out_vec, out_idx} !== 8'h00) begin n_errors++; $display("FAIL rst_mid_regs: got %h need 00", {read_addr1, read_param, out_vec, out_idx}); end
        while (obs_q.size() > 0) begin
            ob = obs_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin n_errors++; $display("FAIL rst_mid_beat: extra beat got %h need none", ob.data); continue; end
            ex = exp_q.pop_front();
            if ({ob.data, ob.vec, ob.idx} !== {ex.data, ex.vec, ex.idx}) begin
                n_errors++; $display("FAIL rst_mid_beat v%0d e%0d: got %h need %h", ex.vec, ex.idx, ob.data, ex.data);
            end
        end
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        repeat (5) begin @(negedge clock); if (done || out_valid || busy) nd++; end
        n_checks++; if (nd != 0) begin n_errors++; $display("FAIL rst_mid_no_done: got %0d active cycles need 0", nd); end
        run_drain(3, 1'b1, 0, 0, 1'b0);
        while (obs_q.size() > 0) begin
            ob = obs_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin n_errors++; $display("FAIL rst_restart_beat: extra beat got %h need none", ob.data); continue; end
            ex = exp_q.pop_front();
            if ({ob.data, ob.vec, ob.idx, ob.last, ob.op, ob.a1} !== {ex.data, ex.vec, ex.idx, ex.last, ex.op, ex.a1}) begin
                n_errors++; $display("FAIL rst_restart_beat v%0d e%0d: got %h need %h", ex.vec, ex.idx, ob.data, ex.data);
            end
        end
        n_checks++; if (exp_q.size() != 0 || r_n_hs != 16 || r_n_done != 1) begin n_errors++; $display("FAIL rst_restart_count: got %0d beats %0d done need 16 1", r_n_hs, r_n_done); end
        exp_q.delete();
    endtask

    initial begin
        #2;
        test_reset();
        test_row_drain();
        test_diag_drain();
        test_backpressure();
        test_start_handling();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit need completion");
        $fatal(1);
    end
endmodule
